// File: rtl/mem_rd_burst_ctrl.sv
// -----------------------------------------------------------------------------
// mem_rd_burst_ctrl
//
// AXI-style read-burst slave in front of a synchronous-read memory. One
// transaction is handled at a time: the AR beat is latched, then each data
// beat is produced by a READ cycle (memory strobe) followed by a DATA cycle
// (R beat presented until handshaken). Illegal bursts still return LEN+1
// beats, each with SLVERR and zero data, and never touch the memory.
//
// Parameters
//   ADDR_WIDTH  AR address width
//   DATA_WIDTH  R data width (also the memory word width)
//   ID_WIDTH    ARID / RID width
//   MEM_AW      memory read-address width
//
// Ports
//   clk        single clock
//   clr        synchronous active-high reset
//   ARVALID    read address valid                (in)
//   ARREADY    read address ready                (out)
//   ARID       transaction ID                    (in)
//   ARADDR     start byte address                (in)
//   ARLEN      beats minus 1                     (in)
//   ARSIZE     log2 of bytes per beat            (in)
//   ARBURST    00 FIXED, 01 INCR, 10 WRAP        (in)
//   mem_rd_en  memory read strobe                (out)
//   mem_raddr  memory byte address               (out)
//   mem_rdata  memory data, valid the cycle after mem_rd_en (in)
//   RVALID     read data valid                   (out)
//   RREADY     read data ready                   (in)
//   RID        echo of ARID                      (out)
//   RDATA      read data                         (out)
//   RRESP      00 OKAY, 10 SLVERR                (out)
//   RLAST      final beat of the burst           (out)
// -----------------------------------------------------------------------------
module mem_rd_burst_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_AW     = 7
) (
    input  logic                  clk,
    input  logic                  clr,

    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,

    output logic                  mem_rd_en,
    output logic [MEM_AW-1:0]     mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest legal beat: log2 of the data bus width in bytes.
    localparam int         MAX_SIZE   = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_arready;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic [3:0]            r_beat;
    logic                  r_fresh;   // first DATA cycle of a legal beat
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [1:0]            w_next_state;
    logic                  w_ar_fire;
    logic                  w_r_fire;
    logic                  w_last;
    logic                  w_ar_wrap_len_ok;
    logic [ADDR_WIDTH-1:0] w_ar_size_mask;
    logic                  w_ar_err;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_incr_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign w_ar_fire = (r_state == S_IDLE) && r_arready && ARVALID;
    assign w_r_fire  = (r_state == S_DATA) && RREADY;
    assign w_last    = (r_beat == r_len);

    // -------------------------------------------------------------------------
    // Burst legality, evaluated on the AR inputs so the verdict is latched
    // together with the rest of the request.
    // -------------------------------------------------------------------------
    assign w_ar_wrap_len_ok = ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15};
    assign w_ar_size_mask   = (ADDR_WIDTH'(1) << ARSIZE) - ADDR_WIDTH'(1);

    assign w_ar_err = (ARBURST == BURST_RSVD)
                   || (ARSIZE > MAX_SIZE_L)
                   || ((ARBURST == BURST_WRAP) && !w_ar_wrap_len_ok)
                   || ((ARBURST == BURST_WRAP) && ((ARADDR & w_ar_size_mask) != '0));

    // -------------------------------------------------------------------------
    // Next beat address. For WRAP the window is (LEN+1)<<SIZE bytes; only the
    // bits inside the window advance, the bits above it are kept.
    // -------------------------------------------------------------------------
    assign w_step      = ADDR_WIDTH'(1) << r_size;
    assign w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
    assign w_incr_addr = r_addr + w_step;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        w_next_addr = r_addr;
        case (r_burst)
            BURST_INCR:  w_next_addr = w_incr_addr;
            BURST_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
            BURST_FIXED: w_next_addr = r_addr;
            default:     w_next_addr = r_addr;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_ar_fire) w_next_state = S_READ;
            S_READ:  w_next_state = S_DATA;
            S_DATA:  if (w_r_fire) w_next_state = w_last ? S_IDLE : S_READ;
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_err     <= 1'b0;
            r_beat    <= '0;
            r_fresh   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next_state;

            // ARREADY is registered: it rises the cycle after reset is
            // released and the cycle after the last R beat is accepted.
            r_arready <= (w_next_state == S_IDLE);

            // The memory output is valid during the first DATA cycle only by
            // contract; it is captured at the end of that cycle so the beat
            // stays stable however long RREADY is held low.
            r_fresh <= (r_state == S_READ) && !r_err;
            if (r_fresh) begin
                r_rdata <= mem_rdata;
            end

            if (w_ar_fire) begin
                r_id    <= ARID;
                r_addr  <= ARADDR;
                r_len   <= ARLEN;
                r_size  <= ARSIZE;
                r_burst <= ARBURST;
                r_err   <= w_ar_err;
                r_beat  <= '0;
            end

            if (w_r_fire && !w_last) begin
                r_addr <= w_next_addr;
                r_beat <= r_beat + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ARREADY   = r_arready;

    // Error bursts walk through READ without strobing the memory.
    assign mem_rd_en = (r_state == S_READ) && !r_err;
    assign mem_raddr = r_addr[MEM_AW-1:0];

    assign RVALID    = (r_state == S_DATA);
    assign RLAST     = (r_state == S_DATA) && w_last;
    assign RID       = r_id;
    assign RRESP     = r_err ? RESP_SLVERR : RESP_OKAY;

    // Bypass the memory output during the first DATA cycle so the beat is
    // presented two cycles after the AR handshake, then serve the capture.
    assign RDATA     = r_err   ? '0 :
                       r_fresh ? mem_rdata : r_rdata;

endmodule

// File: tb/tb_mem_rd_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_rd_burst_ctrl
//
// Directed bench for mem_rd_burst_ctrl. A synchronous-read memory model holds
// a recognisable word per byte address; bursts are issued with hand-computed
// expected memory addresses, beat timing, responses and RLAST positions.
// -----------------------------------------------------------------------------
module tb_mem_rd_burst_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int MAW = 7;

    logic           clk = 1'b0;
    logic           clr;
    logic           ARVALID;
    logic           ARREADY;
    logic [IW-1:0]  ARID;
    logic [AW-1:0]  ARADDR;
    logic [3:0]     ARLEN;
    logic [2:0]     ARSIZE;
    logic [1:0]     ARBURST;
    logic           mem_rd_en;
    logic [MAW-1:0] mem_raddr;
    logic [DW-1:0]  mem_rdata = '0;
    logic           RVALID;
    logic           RREADY;
    logic [IW-1:0]  RID;
    logic [DW-1:0]  RDATA;
    logic [1:0]     RRESP;
    logic           RLAST;

    mem_rd_burst_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .MEM_AW     (MAW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .mem_rd_en (mem_rd_en),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RID       (RID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- memory
    function automatic logic [DW-1:0] word_at(input logic [MAW-1:0] a);
        return 32'hC0DE_0000 | {25'd0, a};
    endfunction

    logic [DW-1:0] mem [0:127];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = word_at(MAW'(i));
    end

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) mem_rdata <= mem[mem_raddr];
    end

    // Log of every memory strobe, sampled mid-cycle.
    logic [MAW-1:0] rd_q [$];
    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) rd_q.push_back(mem_raddr);
    end

    // --------------------------------------------------------------- checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Captured beats of the current burst.
    logic [DW-1:0]  b_data [16];
    logic [1:0]     b_resp [16];
    logic           b_last [16];
    logic [IW-1:0]  b_id   [16];
    int             b_cyc  [16];
    int             n_beats;
    logic [MAW-1:0] exp_a  [16];

    task automatic set_exp(input logic [MAW-1:0] a0, a1, a2, a3);
        exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2; exp_a[3] = a3;
    endtask

    // Present one AR beat; returns at the negedge right after the handshake.
    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int w;
        rd_q.delete();
        @(negedge clk);
        ARVALID = 1'b1; ARID = id; ARADDR = addr;
        ARLEN = len; ARSIZE = size; ARBURST = burst;
        w = 0;
        while (ARREADY !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ar_ready", ARREADY, 1'b1);
        @(negedge clk);
        ARVALID = 1'b0;
    endtask

    // Accept nb beats with RREADY high, optionally stalling one beat.
    // cyc counts cycles after the AR handshake (1 = first cycle after).
    task automatic collect(input int nb, input int stall_beat, input int stall_cyc);
        int            cyc;
        logic [DW-1:0] d0;
        logic          l0;
        cyc = 1;
        n_beats = 0;
        RREADY = 1'b1;
        while (n_beats < nb && cyc < 200) begin
            if (RVALID === 1'b1) begin
                if (n_beats == stall_beat && stall_cyc > 0) begin
                    d0 = RDATA;
                    l0 = RLAST;
                    RREADY = 1'b0;
                    repeat (stall_cyc) begin
                        @(negedge clk);
                        cyc++;
                        check("stall_rvalid", RVALID, 1'b1);
                        check("stall_rdata", RDATA, d0);
                        check("stall_rlast", RLAST, l0);
                        check("stall_rd_en", mem_rd_en, 1'b0);
                    end
                    RREADY = 1'b1;
                end
                b_data[n_beats] = RDATA;
                b_resp[n_beats] = RRESP;
                b_last[n_beats] = RLAST;
                b_id[n_beats]   = RID;
                b_cyc[n_beats]  = cyc;
                n_beats++;
            end
            @(negedge clk);
            cyc++;
        end
        check("beat_count", n_beats, nb);
        check("post_rvalid", RVALID, 1'b0);
        check("post_arready", ARREADY, 1'b1);
    endtask

    // Compare captured beats with expectations.
    task automatic check_beats(input string nm, input int nb, input logic err,
                               input logic [IW-1:0] id, input int last_cyc);
        check($sformatf("%s_rd_count", nm), rd_q.size(), err ? 0 : nb);
        check($sformatf("%s_first_lat", nm), b_cyc[0], 2);
        check($sformatf("%s_last_cyc", nm), b_cyc[nb-1], last_cyc);
        for (int i = 0; i < nb; i++) begin
            check($sformatf("%s_last%0d", nm, i), b_last[i], (i == nb - 1));
            check($sformatf("%s_resp%0d", nm, i), b_resp[i], err ? 2'b10 : 2'b00);
            check($sformatf("%s_id%0d", nm, i), b_id[i], id);
            if (err) begin
                check($sformatf("%s_data%0d", nm, i), b_data[i], 0);
            end else begin
                check($sformatf("%s_data%0d", nm, i), b_data[i], word_at(exp_a[i]));
                if (i < rd_q.size())
                    check($sformatf("%s_addr%0d", nm, i), rd_q[i], exp_a[i]);
            end
        end
    endtask

    // Illegal requests: burst, len, size, addr, beats.
    logic [1:0]  e_burst [4] = '{2'b11, 2'b10, 2'b01, 2'b10};
    logic [3:0]  e_len   [4] = '{4'd1,  4'd2,  4'd0,  4'd3};
    logic [2:0]  e_size  [4] = '{3'd2,  3'd2,  3'd3,  3'd2};
    logic [31:0] e_addr  [4] = '{32'h20, 32'h00, 32'h30, 32'h0E};

    // ---------------------------------------------------------------- stimulus
    initial begin
        int seen;
        int g;
        clr = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = '0;
        ARLEN = '0; ARSIZE = '0; ARBURST = '0; RREADY = 1'b0;

        // Reset values while clr is held.
        @(negedge clk);
        @(negedge clk);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_rlast", RLAST, 1'b0);
        check("rst_rdata", RDATA, 0);
        check("rst_rid", RID, 0);
        check("rst_rresp", RRESP, 2'b00);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_raddr", mem_raddr, 0);
        clr = 1'b0;
        @(negedge clk);
        check("rst_arready_after", ARREADY, 1'b1);

        // INCR 0x80, 4 beats of 2 bytes.
        set_exp(7'h00, 7'h02, 7'h04, 7'h06);
        send_ar(4'h5, 32'h80, 4'd3, 3'd1, 2'b01);
        collect(4, -1, 0);
        check_beats("incr", 4, 1'b0, 4'h5, 8);

        // WRAP 0x0C, 4 beats of 4 bytes -> wraps inside a 16-byte window.
        set_exp(7'h0C, 7'h00, 7'h04, 7'h08);
        send_ar(4'h2, 32'h0C, 4'd3, 3'd2, 2'b10);
        collect(4, -1, 0);
        check_beats("wrap", 4, 1'b0, 4'h2, 8);

        // FIXED 0x14, 3 beats.
        set_exp(7'h14, 7'h14, 7'h14, 7'h00);
        send_ar(4'hA, 32'h14, 4'd2, 3'd0, 2'b00);
        collect(3, -1, 0);
        check_beats("fixed", 3, 1'b0, 4'hA, 6);

        // Illegal requests all return SLVERR beats without memory reads.
        for (int k = 0; k < 4; k++) begin
            send_ar(4'(k + 8), e_addr[k], e_len[k], e_size[k], e_burst[k]);
            collect(int'(e_len[k]) + 1, -1, 0);
            check_beats($sformatf("err%0d", k), int'(e_len[k]) + 1, 1'b1,
                        4'(k + 8), 2 * (int'(e_len[k]) + 1));
        end

        // INCR with beat 2 stalled for 5 cycles.
        set_exp(7'h10, 7'h14, 7'h18, 7'h1C);
        send_ar(4'h7, 32'h10, 4'd3, 3'd2, 2'b01);
        collect(4, 1, 5);
        check_beats("stall", 4, 1'b0, 4'h7, 13);

        // clr during DATA of beat 2.
        send_ar(4'h3, 32'h40, 4'd3, 3'd2, 2'b01);
        RREADY = 1'b1;
        seen = 0;
        g = 0;
        while (seen < 2 && g < 50) begin
            if (RVALID === 1'b1) seen++;
            if (seen < 2) begin
                @(negedge clk);
                g++;
            end
        end
        check("clr_reach_beat2", seen, 2);
        clr = 1'b1;
        @(negedge clk);
        check("clr_rvalid", RVALID, 1'b0);
        check("clr_arready", ARREADY, 1'b0);
        check("clr_rd_en", mem_rd_en, 1'b0);
        clr = 1'b0;
        @(negedge clk);
        check("clr_arready_after", ARREADY, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("clr_quiet%0d", i), {RVALID, mem_rd_en}, 2'b00);
        end
        check("clr_rd_count", rd_q.size(), 2);

        // Fresh INCR after the abandoned burst; misaligned is fine for INCR.
        set_exp(7'h1E, 7'h22, 7'h00, 7'h00);
        send_ar(4'h6, 32'h9E, 4'd1, 3'd2, 2'b01);
        collect(2, -1, 0);
        check_beats("after_clr", 2, 1'b0, 4'h6, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_rd_burst_ctrl.md
MEM_RD_BURST_CTRL -- requirements
Module: mem_rd_burst_ctrl

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 32, R data width, which is also the memory word width.
- ID_WIDTH, 4, ARID/RID width.
- MEM_AW, 7, memory read-address width.

REQ-002 Ports SHALL be (one per line: name direction width meaning). The block has one clock; reset is synchronous and active-high.
- clk  in  1  single clock.
- clr  in  1  synchronous active-high reset.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARID  in  ID_WIDTH  transaction ID.
- ARADDR  in  ADDR_WIDTH  start byte address.
- ARLEN  in  4  beats minus 1.
- ARSIZE  in  3  log2 of bytes per beat.
- ARBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- mem_rd_en  out  1  memory read strobe.
- mem_raddr  out  MEM_AW  memory byte address, equal to the current address [MEM_AW-1:0].
- mem_rdata  in  DATA_WIDTH  memory data, valid one cycle after mem_rd_en.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RID  out  ID_WIDTH  echo of ARID.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  response: 00 OKAY, 10 SLVERR.
- RLAST  out  1  final beat of the burst.

Function
REQ-003 FSM states SHALL be IDLE, READ and DATA, and the block SHALL handle one transaction at a time.
REQ-004 IDLE: ARREADY=1. On ARVALID&ARREADY, latch ID, ADDR, LEN, SIZE and BURST, clear the beat counter, and go to READ.
REQ-005 READ: mem_rd_en=1 for exactly one cycle with mem_raddr=addr[MEM_AW-1:0], then go to DATA.
REQ-006 DATA, entry: RDATA<=mem_rdata and RVALID=1. RDATA, RID, RRESP and RLAST SHALL be held stable until RVALID&RREADY.
REQ-007 DATA, handshake on the last beat: go to IDLE with RVALID=0 on the next cycle.
REQ-008 DATA, handshake on any other beat: update the address, increment the beat counter, and go to READ.
REQ-009 Latency SHALL be fixed:
- AR handshake at cycle T; mem_rd_en at T+1; first RVALID at T+2.
- With RREADY held high, each beat takes 2 cycles.
REQ-010 RLAST SHALL be 1 exactly when beat counter == latched LEN.
REQ-011 Address update SHALL depend on the burst type:
- FIXED: address unchanged.
- INCR: addr + (1<<SIZE), modulo 2^ADDR_WIDTH with the carry discarded.
- WRAP: the boundary is (LEN+1)<<SIZE. The low bits within the boundary increment and wrap, and the high bits are held.
REQ-012 Error cases SHALL return SLVERR on every beat with RDATA=0 and mem_rd_en suppressed, and still return LEN+1 beats with correct RLAST. An error case is any of:
- ARBURST=11;
- WRAP with LEN not in {1,3,7,15};
- ARSIZE > log2(DATA_WIDTH/8);
- WRAP with a start address not aligned to SIZE.
REQ-013 A legal burst SHALL return RRESP=00 on every beat.
REQ-014 ARREADY SHALL be 0 in READ and DATA, so no new AR is accepted until RLAST is handshaken.
REQ-015 While RVALID=1 and RREADY=0, the block SHALL keep mem_rd_en=0 and hold all state.
REQ-016 RREADY asserted while RVALID=0 SHALL have no effect.

Reset
REQ-017 clr=1 at a clock edge SHALL force state=IDLE and the outputs to ARREADY=0 during clr, then 1 on the first cycle after, with RVALID=0, RLAST=0, RDATA=0, RID=0, RRESP=00, mem_rd_en=0 and mem_raddr=0.
REQ-018 clr during READ or DATA SHALL abandon the burst with no further beats, and the next AR SHALL start cleanly.

Verification
REQ-019 INCR, ARADDR=0x80, ARLEN=3, ARSIZE=1, RREADY=1 -> mem_raddr sequence 0x00, 0x02, 0x04, 0x06; 4 beats; RLAST on beat 4 only; RRESP=00; first RVALID 2 cycles after AR.
REQ-020 WRAP, ARADDR=0x0C, ARLEN=3, ARSIZE=2 -> mem_raddr sequence 0x0C, 0x00, 0x04, 0x08.
REQ-021 FIXED, ARADDR=0x14, ARLEN=2, ARSIZE=0 -> mem_raddr 0x14 three times; RID equals ARID on all beats.
REQ-022 ARBURST=11, ARLEN=1 -> 2 beats, each with RRESP=10 and RDATA=0; mem_rd_en never asserted; RLAST on beat 2.
REQ-023 RREADY low for 5 cycles on beat 2 of an INCR burst (ARLEN=3) -> RDATA and RLAST held stable; no mem_rd_en while stalled; burst completes normally after release.
REQ-024 clr pulsed during DATA of beat 2 of an INCR burst (ARLEN=3) -> RVALID=0 the next cycle and ARREADY=1 after clr deasserts; a following AR with ARADDR=0x9E, ARLEN=1, ARSIZE=2 returns 2 OKAY beats (that address is misaligned for SIZE=2, but misalignment is an error only for WRAP).
